anomaly_alert_tx: RTL and testbench



---
 rtl/anomaly_pkg.sv | 15 +
 rtl/anomaly_alert_tx_if.sv | 8 +
 rtl/event_fifo.sv | 46 ++++
 rtl/anomaly_alert_tx.sv | 150 +++++++++++++++
 tb/tb_anomaly_alert_tx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/anomaly_pkg.sv
// Shared definitions for the anomaly alert transmit path: serialiser states,
// default sync byte and message length.
package anomaly_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MSG_BYTES     = 3;

endpackage

// File: rtl/anomaly_alert_tx_if.sv
// Anomaly event strobe from the detector: one sample per valid cycle, no backpressure.
interface anomaly_alert_tx_if;
  logic       event_valid;
  logic [7:0] event_sample;

  modport master (output event_valid, output event_sample);
  modport slave  (input  event_valid, input  event_sample);
endinterface

// File: rtl/event_fifo.sv
// Synchronous FIFO with occupancy count; the caller guarantees no push when
// full and no pop when empty.
module event_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage is data only and carries no reset; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/anomaly_alert_tx.sv
// Queues anomaly events and sends each as a 3-byte UART 8N1 message:
// sync byte, flagged sample, message sequence number.
module anomaly_alert_tx
  import anomaly_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  anomaly_alert_tx_if.slave           evt,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_count
);

  localparam int             TW        = $clog2(CLKS_PER_BIT);
  localparam int             LW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0]  RELOAD    = TW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]     LAST_BYTE = 2'(MSG_BYTES - 1);

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [1:0]    byte_idx, byte_idx_n;
  logic [7:0]    seq, seq_n;
  logic [7:0]    sample_q, sample_n;
  logic [7:0]    cur_byte;
  logic [7:0]    head;
  logic [LW-1:0] level_n;
  logic          push, pop, full, empty;
  logic          bit_end, tx_n, busy_n;

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
  assign push = evt.event_valid & ~full;

  event_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (evt.event_sample),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = SYNC_BYTE;
      2'd1:    cur_byte = sample_q;
      default: cur_byte = seq;
    endcase
  end

  assign bit_end = (timer == '0);

  always_comb begin
    state_n    = state;
    timer_n    = bit_end ? RELOAD : timer - 1'b1;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    seq_n      = seq;
    sample_n   = sample_q;
    pop        = 1'b0;
    tx_n       = 1'b1;
    case (state)
      IDLE: begin
        timer_n = RELOAD;
        if (!empty) begin
          pop        = 1'b1;
          sample_n   = head;
          byte_idx_n = 2'd0;
          state_n    = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          bit_idx_n = 3'd0;
          state_n   = DATA;
        end
      end
      DATA: begin
        tx_n = cur_byte[bit_idx];
        if (bit_end) begin
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx != LAST_BYTE) begin
            byte_idx_n = byte_idx + 2'd1;
            state_n    = START;
          end else begin
            // Chain straight into the next queued message with no idle gap.
            seq_n = seq + 8'd1;
            if (!empty) begin
              pop        = 1'b1;
              sample_n   = head;
              byte_idx_n = 2'd0;
              state_n    = START;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign level_n = fifo_level + LW'(push) - LW'(pop);
  assign busy_n  = (state_n != IDLE) | (level_n != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= RELOAD;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
      seq        <= 8'd0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      seq      <= seq_n;
      tx       <= tx_n;
      busy     <= busy_n;
      if (evt.event_valid && full && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    sample_q <= sample_n;
  end

endmodule

// File: tb/tb_anomaly_alert_tx.sv
// Scoreboard bench: stimulus queues expected UART bytes, a negedge UART
// decoder pops and compares each received byte.
module tb_anomaly_alert_tx;

  localparam int CPB = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;

  int total = 0;
  int bad = 0;
  int mon_total = 0;
  int mon_bad = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  logic [7:0] exp_seq = 8'd0;

  anomaly_alert_tx_if ev ();

  anomaly_alert_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .evt        (ev),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART receive monitor, sampling mid-bit on the falling edge.
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_byte = 8'd0;
  logic [7:0] m_exp;

  always @(negedge clk) begin
    if (!reset) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (tx === 1'b0) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        start_q.push_back(cyc);
      end
    end else begin
      m_cnt = m_cnt + 1;
      if ((m_cnt % CPB) == CPB / 2) begin
        if (m_cnt / CPB >= 1 && m_cnt / CPB <= 8) begin
          m_byte[3'(m_cnt / CPB - 1)] = tx;
        end else if (m_cnt / CPB == 9) begin
          m_busy = 1'b0;
          mon_total = mon_total + 1;
          if (tx !== 1'b1) begin
            mon_bad = mon_bad + 1;
            $display("FAIL stop_bit: got %b, want 1", tx);
          end
          mon_total = mon_total + 1;
          if (exp_q.size() == 0) begin
            mon_bad = mon_bad + 1;
            $display("FAIL uart_byte: got %02h, want nothing (no byte expected)", m_byte);
          end else begin
            m_exp = exp_q.pop_front();
            if (m_byte !== m_exp) begin
              mon_bad = mon_bad + 1;
              $display("FAIL uart_byte: got %02h, want %02h", m_byte, m_exp);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_msg(input logic [7:0] s);
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    exp_q.push_back(exp_seq);
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic send(input logic [7:0] s);
    ev.event_valid  = 1'b1;
    ev.event_sample = s;
    step(1);
    ev.event_valid  = 1'b0;
    expect_msg(s);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    step(2);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    exp_seq = 8'd0;
    step(3);
    reset = 1'b1;
    step(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s;
    logic       acc;
    ev.event_valid  = 1'b0;
    ev.event_sample = 8'd0;
    step(3);
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 200; i++) begin
      step(1);
      check("reset_idle", {19'd0, tx, busy, fifo_level, drop_count},
            {19'd0, 1'b1, 1'b0, 3'd0, 8'd0});
    end

    // Single event: latency, length, busy fall
    start_q.delete();
    send(8'h3C);
    step(1);
    check("lat_edge1_tx", {31'd0, tx}, 32'd1);
    step(1);
    check("lat_edge2_tx", {31'd0, tx}, 32'd0);
    step(118);
    check("busy_last_cycle", {31'd0, busy}, 32'd1);
    check("stop_tx_high", {31'd0, tx}, 32'd1);
    step(1);
    check("busy_fall", {31'd0, busy}, 32'd0);
    step(5);
    check("single_bytes", start_q.size(), 32'd3);
    if (start_q.size() == 3) check("single_span", start_q[2] - start_q[0], 32'd80);

    // Three queued events, back to back
    start_q.delete();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    wait_idle(2000, "queued_drain");
    check("queued_bytes", start_q.size(), 32'd9);
    for (int i = 0; i + 1 < start_q.size(); i++)
      check("queued_gap", start_q[i+1] - start_q[i], 32'd40);

    // Overflow: six events, then 300 more pushes; pops at N+121/N+241 free one slot each
    for (int i = 0; i < 306; i++) begin
      s   = (i < 6) ? 8'h41 + 8'(i) : 8'(i - 6);
      acc = (i < 5) || (i == 6 + 116) || (i == 6 + 236);
      ev.event_valid  = 1'b1;
      ev.event_sample = s;
      step(1);
      if (acc) expect_msg(s);
      if (i == 5) begin
        check("drop_after_six", drop_count, 32'd1);
        check("level_after_six", fifo_level, 32'd4);
      end
    end
    ev.event_valid = 1'b0;
    check("drop_saturate", drop_count, 32'd255);
    wait_idle(3000, "overflow_drain");
    check("drop_hold", drop_count, 32'd255);

    // Mid-frame reset during bit 3 of byte 1 (sample 77 -> bit 3 is 0)
    send(8'h77);
    step(59);
    check("mid_frame_low", {31'd0, tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("async_tx_high", {31'd0, tx}, 32'd1);
    check("reset_level", fifo_level, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_drop", drop_count, 32'd0);
    exp_q.delete();
    exp_seq = 8'd0;
    step(3);
    reset = 1'b1;
    step(3);
    check("after_reset_tx", {31'd0, tx}, 32'd1);
    send(8'h88);
    wait_idle(400, "post_reset_drain");

    // Sequence wrap over 257 messages
    do_reset();
    for (int i = 0; i < 257; i++) begin
      send(8'(i));
      wait_idle(400, "wrap_drain");
    end
    check("wrap_seq_model", exp_seq, 32'd1);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    total = total + mon_total;
    bad = bad + mon_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
